// File: rtl/mux2_to_1.sv
// mux2_to_1: two-input word mux with a combinational output and a
// valid-qualified registered copy of the same selection.
module mux2_to_1 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_data_q,
    output logic             o_valid
);
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;
    // An unknown select propagates X rather than favouring either input.
    always_comb begin
        case (sel)
            1'b0:    o_data = data_a;
            1'b1:    o_data = data_b;
            default: o_data = 'x;
        endcase
    end
    always_comb begin
        data_d  = rst ? RST_VAL : in_valid ? o_data : data_q;
        valid_d = !rst && in_valid;
    end
    always_ff @(posedge clk) begin
        data_q  <= data_d;
        valid_q <= valid_d;
    end
    assign o_data_q = data_q;
    assign o_valid  = valid_q;
endmodule

// File: tb/tb_mux2_to_1.sv
// tb_mux2_to_1: scoreboard bench over WIDTH=1, WIDTH=8 and WIDTH=32 instances.
module tb_mux2_to_1;
    localparam logic [7:0] RST8 = 8'h96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a1, b1, s1, v1, o1, oq1, ov1;
    logic [7:0]  a8, b8, o8, oq8;
    logic        s8, v8, ov8;
    logic [31:0] a32, b32, o32, oq32;
    logic        s32, v32, ov32;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0]  sb8[$];
    logic [32:0] sb32[$];
    logic [7:0]  sbc8[$];
    logic [31:0] sbc32[$];
    logic        sbc1[$];
    logic [8:0]  m8;
    logic [32:0] m32;

    mux2_to_1 #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .data_a(a1), .data_b(b1), .sel(s1), .in_valid(v1),
        .o_data(o1), .o_data_q(oq1), .o_valid(ov1)
    );
    mux2_to_1 #(.WIDTH(8), .RST_VAL(RST8)) u8 (
        .clk(clk), .rst(rst), .data_a(a8), .data_b(b8), .sel(s8), .in_valid(v8),
        .o_data(o8), .o_data_q(oq8), .o_valid(ov8)
    );
    mux2_to_1 #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .data_a(a32), .data_b(b32), .sel(s32), .in_valid(v32),
        .o_data(o32), .o_data_q(oq32), .o_valid(ov32)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Push expectations for the inputs now applied, clock once, then pop and compare.
    task automatic step();
        m8  = rst ? {1'b0, RST8}  : v8  ? {1'b1, s8 ? b8 : a8}    : {1'b0, m8[7:0]};
        m32 = rst ? {1'b0, 32'h0} : v32 ? {1'b1, s32 ? b32 : a32} : {1'b0, m32[31:0]};
        sb8.push_back(m8);
        sb32.push_back(m32);
        sbc8.push_back(s8 ? b8 : a8);
        sbc32.push_back(s32 ? b32 : a32);
        @(posedge clk);
        #1;
        chk("o_data8", o8, sbc8.pop_front());
        chk("o_data32", o32, sbc32.pop_front());
        chk("reg8", {ov8, oq8}, sb8.pop_front());
        chk("reg32", {ov32, oq32}, sb32.pop_front());
    endtask

    initial begin
        logic [7:0] tt;
        rst = 1'b1;
        {a1, b1, s1, v1} = '0;
        {a8, b8, s8, v8} = '0;
        {a32, b32, s32, v32} = '0;
        a8 = 8'h11;
        b8 = 8'h22;
        step();
        s8 = 1'b1;
        step();
        chk("rst_valid1", ov1, 1'b0);
        chk("rst_data1", oq1, 1'b0);

        rst = 1'b0;
        a8 = 8'h5A; b8 = 8'hC3; v8 = 1'b1; s8 = 1'b0;
        step();
        s8 = 1'b1;
        step();

        v8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s8 = ~s8;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            step();
        end

        v8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            s8 = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        a8 = 8'h3C;
        s8 = 1'b0;
        step();

        rst = 1'b1;
        #2;
        chk("pulse_valid", ov8, m8[8]);
        chk("pulse_data", oq8, m8[7:0]);
        rst = 1'b0;
        #1;
        chk("post_pulse_valid", ov8, m8[8]);
        chk("post_pulse_data", oq8, m8[7:0]);
        v8 = 1'b0;
        step();

        tt = 8'b11011000;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, s1} = 3'(i);
            sbc1.push_back(tt[i]);
            #10;
            chk("comb1", o1, sbc1.pop_front());
            #10;
        end

        #1;
        for (int i = 0; i < 1000; i++) begin
            a32 = $urandom;
            b32 = $urandom;
            s32 = 1'($urandom_range(0, 1));
            v32 = 1'($urandom_range(0, 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
